tube_write_sched: RTL and testbench
===================================

# tube_write_sched

Write scheduler and scan-tick source for the 8-digit seven-segment tube datapath.
- Arbitrates round-robin between two 32-bit display requesters (CPU bus port 0, debug/monitor port 1).
- Sequences each accepted word into the tube's two-beat half-word write protocol, high half first.
- Generates the periodic scan tick that advances digit selection.
- Is the only block that drives the tube's write enable and data inputs.

## Interface
- CPU_WIDTH, 16: tube write beat width; display word is 2*CPU_WIDTH bits.
- SCAN_DIV, 50000: scan tick period in clk cycles, ≥ 2.
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 has a word to display.
- req0_data  in  2*CPU_WIDTH  port 0 word; bits [2*CPU_WIDTH-1:CPU_WIDTH] are the high half.
- req0_ready  out  1  port 0 word accepted this cycle.
- req1_valid  in  1  port 1 has a word to display.
- req1_data  in  2*CPU_WIDTH  port 1 word.
- req1_ready  out  1  port 1 word accepted this cycle.
- tube_we  out  1  write beat strobe to the tube datapath.
- tube_num  out  CPU_WIDTH  write beat data to the tube datapath.
- scan_tick  out  1  one-cycle digit-advance pulse.
- busy  out  1  high while a word is being sequenced.

## Operation
- FSM states: IDLE, HI, LO.
- IDLE:
  - If any valid is high, grant one requester.
  - Assert that requester's ready combinationally in the same cycle; a transfer occurs when valid && ready.
  - Capture its data into word_q; move to HI.
- HI: tube_we=1, tube_num=word_q high half; move to LO.
- LO: tube_we=1, tube_num=word_q low half; move to IDLE.
- Requests are never accepted in HI or LO; both ready outputs are 0 there.
- Arbitration:
  - last_grant register, reset to 1.
  - If exactly one valid is high, that port wins.
  - If both are high, the port other than last_grant wins.
  - last_grant updates only on a transfer.
- Outputs in IDLE: tube_we=0, tube_num=0.
- busy = (state != IDLE).
- Requesters hold valid and data stable until ready. Dropping valid before ready is legal; no transfer occurs.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - scan_tick=1 exactly in the cycles where scan_cnt == SCAN_DIV-1.
  - Free-running, independent of the FSM.
- Reset values: state=IDLE, word_q=0, last_grant=1, scan_cnt=0.
- Output values during reset: tube_we=0, tube_num=0, scan_tick=0, busy=0, req0_ready=0, req1_ready=0.
- Reset mid-sequence (HI or LO):
  - Aborts immediately to IDLE and drops tube_we asynchronously.
  - The tube datapath shares the same reset, so its beat-pairing flag realigns with this FSM.

## Timing
- Transfer in cycle N:
  - First tube_we beat (high half) is visible in cycle N+1.
  - Second beat (low half) is visible in cycle N+2.
  - Next transfer is possible in cycle N+3 at the earliest.
- Sustained throughput: one word per 3 cycles.
- Back-to-back with both valid held high: grants alternate 0,1,0,1…; each port gets one word per 6 cycles.
- tube_we and tube_num are decoded from the registered state and word_q only. They have no combinational path from valid or data inputs.
- ready depends combinationally on valid and state.
- scan_tick:
  - First pulse at cycle SCAN_DIV-1 after reset release.
  - Then every SCAN_DIV cycles.
  - Pulse width is exactly 1 cycle.

## Configuration
- TUBE_SCHED_DEDUP_EN defined:
  - Keeps last_word (reset 0) and a last_vld flag (reset 0).
  - On a transfer whose data equals last_word while last_vld=1, the FSM stays in IDLE and issues no tube_we beats. ready still pulses and last_grant still updates.
  - Otherwise the word is sequenced normally; last_word is loaded and last_vld is set at the transfer.
- TUBE_SCHED_DEDUP_EN undefined:
  - Every transfer produces two beats.
  - last_word and last_vld do not exist.

## Test plan
- Reset with req0 valid, data 0x12345678: all outputs 0 during reset. After release: req0_ready=1 in cycle N; tube_we/tube_num = 1/0x1234 in N+1, 1/0x5678 in N+2; tube_we=0 and busy=0 in N+3.
- Both ports valid continuously, req0=0xAAAA0000, req1=0x0000BBBB: grant order 0,1,0,1. Transfers are spaced exactly 3 cycles apart. Beat data matches the granted port.
- req1 drops valid during port 0's HI state: no req1_ready pulse. The FSM returns to IDLE and stays idle, with tube_we=0.
- Assert rst in LO state: tube_we falls without waiting for a clock edge. After release, a fresh word 0xCAFEF00D is written high then low, correctly paired.
- SCAN_DIV=4: scan_tick high at cycles 3, 7, 11 after reset release, each 1 cycle wide, including during active writes.
- With TUBE_SCHED_DEDUP_EN, write 0x00000042 twice: the first produces 2 beats, the second gives a ready pulse and 0 beats. Writing 0x00000043 next produces 2 beats.

Source files
------------

// File: rtl/tube_write_sched.sv
// ---------------------------------------------------------------------------
// tube_write_sched
//
// Write scheduler and scan-tick source for the 8-digit seven-segment tube.
// It arbitrates round-robin between two 32-bit display requesters. Each
// accepted word goes out as two half-word write beats, high half first.
// The block also produces the free-running digit-advance scan tick. It is
// the only driver of the tube's write enable and data inputs.
//
// Parameters
//   CPU_WIDTH  tube write beat width; a display word is 2*CPU_WIDTH bits
//   SCAN_DIV   scan tick period in clk cycles (>= 2)
//
// Ports
//   clk, rst               system clock; asynchronous active-high reset
//   req0_valid/data/ready  CPU bus requester (port 0)
//   req1_valid/data/ready  debug/monitor requester (port 1)
//   tube_we, tube_num      write beat strobe and data to the tube datapath
//   scan_tick              one-cycle digit-advance pulse
//   busy                   high while a word is being sequenced
//
// Optional feature
//   TUBE_SCHED_DEDUP_EN    when defined, a transferred word equal to the
//                          last written word is accepted but not rewritten
// ---------------------------------------------------------------------------
module tube_write_sched #(
   parameter int CPU_WIDTH = 16,
   parameter int SCAN_DIV  = 50000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   input  logic [2*CPU_WIDTH-1:0] req0_data,
   output logic                   req0_ready,
   input  logic                   req1_valid,
   input  logic [2*CPU_WIDTH-1:0] req1_data,
   output logic                   req1_ready,
   output logic                   tube_we,
   output logic [CPU_WIDTH-1:0]   tube_num,
   output logic                   scan_tick,
   output logic                   busy
);

   localparam int                SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [2*CPU_WIDTH-1:0] word_q;
   logic                   last_grant_q;
   logic [SCAN_W-1:0]      scan_cnt_q;

   logic                   grant_sel;
   logic                   xfer;
   logic                   skip_word;
   logic [2*CPU_WIDTH-1:0] grant_data;

   // Round-robin choice: a lone valid wins outright. On a tie the port that
   // did not win last time is chosen.
   always_comb begin
      grant_sel = req1_valid;
      if (req0_valid && req1_valid) begin
         grant_sel = ~last_grant_q;
      end
   end

   assign grant_data = grant_sel ? req1_data : req0_data;

   // Ready is only offered from IDLE. It is held low during reset so that a
   // requester waiting through reset is not seen as accepted.
   assign xfer       = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
   assign req0_ready = xfer && !grant_sel;
   assign req1_ready = xfer &&  grant_sel;

`ifdef TUBE_SCHED_DEDUP_EN
   logic [2*CPU_WIDTH-1:0] last_word_q;
   logic                   last_vld_q;

   // A word identical to the one last written is acknowledged but not
   // rewritten, which saves two beats of tube bandwidth.
   assign skip_word = last_vld_q && (grant_data == last_word_q);

   // Remember the most recent word that was actually sequenced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_word_q <= '0;
         last_vld_q  <= 1'b0;
      end else if (xfer && !skip_word) begin
         last_word_q <= grant_data;
         last_vld_q  <= 1'b1;
      end
   end
`else
   assign skip_word = 1'b0;
`endif

   // State register. The asynchronous reset drops tube_we at once, even
   // mid-sequence. The tube's beat-pairing flag shares this reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the granted word and remember who won, on transfers only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q       <= '0;
         last_grant_q <= 1'b1;
      end else if (xfer) begin
         word_q       <= grant_data;
         last_grant_q <= grant_sel;
      end
   end

   // Next state and beat decode. tube_we and tube_num depend only on
   // registered state, never on the request inputs.
   always_comb begin
      state_d  = state_q;
      tube_we  = 1'b0;
      tube_num = '0;
      case (state_q)
         IDLE: begin
            if (xfer && !skip_word) begin
               state_d = HI;
            end
         end
         HI: begin
            tube_we  = 1'b1;
            tube_num = word_q[2*CPU_WIDTH-1:CPU_WIDTH];
            state_d  = LO;
         end
         LO: begin
            tube_we  = 1'b1;
            tube_num = word_q[CPU_WIDTH-1:0];
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q != IDLE);

   // Free-running scan divider. It is independent of the write sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_q <= '0;
      end else if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_q <= '0;
      end else begin
         scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
      end
   end

   assign scan_tick = (scan_cnt_q == SCAN_LAST);

endmodule

// File: tb/tb_tube_write_sched.sv
// ---------------------------------------------------------------------------
// tb_tube_write_sched
//
// Self-checking bench for tube_write_sched (CPU_WIDTH=16, SCAN_DIV=4).
// It has two parts:
//   - a table of directed cycles with hand-derived expected outputs
//   - hand sequences and randomized traffic checked against a queue-based
//     reference model of the beat stream
// ---------------------------------------------------------------------------
module tb_tube_write_sched;

   localparam int W  = 16;
   localparam int SD = 4;
`ifdef TUBE_SCHED_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req0_valid;
   logic [2*W-1:0] req0_data;
   logic           req0_ready;
   logic           req1_valid;
   logic [2*W-1:0] req1_data;
   logic           req1_ready;
   logic           tube_we;
   logic [W-1:0]   tube_num;
   logic           scan_tick;
   logic           busy;

   tube_write_sched #(.CPU_WIDTH(W), .SCAN_DIV(SD)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .tube_we    (tube_we),
      .tube_num   (tube_num),
      .scan_tick  (scan_tick),
      .busy       (busy)
   );

   // 10 time-unit clock period.
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int we_seen  = 0;

   // Reference model: a queue of pending beats, plus the arbitration
   // memory and the optional duplicate-suppression memory.
   logic [W-1:0]   beat_q[$];
   bit             m_last_grant;
   logic [2*W-1:0] m_last_word;
   bit             m_last_vld;
   int             m_cycle;
   bit             e_r0, e_r1, e_we, e_tick, e_busy, e_g;
   logic [W-1:0]   e_num;

   typedef struct {
      bit             rst_first;
      bit             v0;
      logic [2*W-1:0] d0;
      bit             v1;
      logic [2*W-1:0] d1;
      logic [20:0]    exp;
   } row_t;

   row_t tbl[$];

   task automatic addRow(input bit rf, input bit v0, input logic [2*W-1:0] d0,
                         input bit v1, input logic [2*W-1:0] d1,
                         input bit r0, input bit r1, input bit we,
                         input logic [W-1:0] num, input bit tick, input bit bz);
      row_t r;
      r.rst_first = rf;
      r.v0  = v0;
      r.d0  = d0;
      r.v1  = v1;
      r.d1  = d1;
      r.exp = {r0, r1, we, num, tick, bz};
      tbl.push_back(r);
   endtask

   task automatic applyStimulus(input bit v0, input logic [2*W-1:0] d0,
                                input bit v1, input logic [2*W-1:0] d1);
      req0_valid = v0;
      req0_data  = d0;
      req1_valid = v1;
      req1_data  = d1;
   endtask

   task automatic checkOutput(input string name, input logic [20:0] exp);
      logic [20:0] act;
      act = {req0_ready, req1_ready, tube_we, tube_num, scan_tick, busy};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got r0/r1/we/num/tick/busy=%b/%b/%b/%h/%b/%b, expected %b/%b/%b/%h/%b/%b",
                  name, $time, act[20], act[19], act[18], act[17:2], act[1], act[0],
                  exp[20], exp[19], exp[18], exp[17:2], exp[1], exp[0]);
      end
   endtask

   task automatic modelReset();
      beat_q.delete();
      m_last_grant = 1'b1;
      m_last_word  = '0;
      m_last_vld   = 1'b0;
      m_cycle      = 0;
   endtask

   // Expected outputs for the current cycle, from model state and inputs.
   task automatic modelEval();
      e_busy = (beat_q.size() != 0);
      e_we   = e_busy;
      e_num  = e_busy ? beat_q[0] : '0;
      e_g    = (req0_valid && req1_valid) ? !m_last_grant : req1_valid;
      e_r0   = !e_busy && req0_valid && !e_g;
      e_r1   = !e_busy && req1_valid &&  e_g;
      e_tick = ((m_cycle % SD) == SD - 1);
   endtask

   // Retire this cycle's beat and enqueue the beats of any accepted word.
   task automatic modelAdvance();
      logic [2*W-1:0] w;
      if (e_busy) void'(beat_q.pop_front());
      if (e_r0 || e_r1) begin
         w = e_g ? req1_data : req0_data;
         m_last_grant = e_g;
         if (!(DEDUP && m_last_vld && (w == m_last_word))) begin
            beat_q.push_back(w[2*W-1:W]);
            beat_q.push_back(w[W-1:0]);
            m_last_word = w;
            m_last_vld  = 1'b1;
         end
      end
      m_cycle++;
   endtask

   // One model-checked clock cycle. Inputs must already be driven.
   task automatic modelCycle(input string name);
      @(negedge clk);
      modelEval();
      checkOutput(name, {e_r0, e_r1, e_we, e_num, e_tick, e_busy});
      if (tube_we === 1'b1) we_seen++;
      modelAdvance();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
   endtask

   // Send one word from port 0, then idle for three cycles. Returns the
   // number of write beats seen in that window.
   task automatic writeWord(input string name, input logic [2*W-1:0] w, output int beats);
      we_seen = 0;
      applyStimulus(1'b1, w, 1'b0, '0);
      modelCycle(name);
      applyStimulus(1'b0, '0, 1'b0, '0);
      for (int k = 0; k < 3; k++) modelCycle(name);
      beats = we_seen;
   endtask

   function automatic logic [2*W-1:0] pickWord();
      return ($urandom_range(0, 3) == 0) ? 32'h0000_0042 : 32'($urandom);
   endfunction

   initial begin
      int b1, b2, b3;
      bit v0, v1;
      logic [2*W-1:0] d0, d1;

      modelReset();

      // Outputs held at zero during reset, even with a request pending.
      applyStimulus(1'b1, 32'h1234_5678, 1'b0, '0);
      @(negedge clk);
      checkOutput("reset_outputs", '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single write, high half then low half, then back to idle.
      addRow(0, 1, 32'h1234_5678, 0, 0,            1, 0, 0, 16'h0000, 0, 0);
      addRow(0, 0, 0,             0, 0,            0, 0, 1, 16'h1234, 0, 1);
      addRow(0, 0, 0,             0, 0,            0, 0, 1, 16'h5678, 0, 1);
      addRow(0, 0, 0,             0, 0,            0, 0, 0, 16'h0000, 1, 0);
      // Both ports held valid: grants alternate 0,1,0,1, every 3 cycles.
      addRow(1, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 1, 0, 0, 16'h0000, 0, 0);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 0, 0, 1, 16'hAAAA, 0, 1);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 0, 0, 1, 16'h0000, 0, 1);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 0, 1, 0, 16'h0000, 1, 0);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 0, 0, 1, 16'h0000, 0, 1);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 0, 0, 1, 16'hBBBB, 0, 1);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 1, 0, 0, 16'h0000, 0, 0);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 0, 0, 1, 16'hAAAA, 1, 1);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 0, 0, 1, 16'h0000, 0, 1);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 0, 1, 0, 16'h0000, 0, 0);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 0, 0, 1, 16'h0000, 0, 1);
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 0, 0, 1, 16'hBBBB, 1, 1);
      // Port 0 wins, then port 1 withdraws during HI: no req1 ready pulse.
      addRow(0, 1, 32'hAAAA_0000, 1, 32'h0000_BBBB, 1, 0, 0, 16'h0000, 0, 0);
      addRow(0, 0, 0,             0, 0,            0, 0, 1, 16'hAAAA, 0, 1);
      addRow(0, 0, 0,             0, 0,            0, 0, 1, 16'h0000, 0, 1);
      addRow(0, 0, 0,             0, 0,            0, 0, 0, 16'h0000, 1, 0);
      addRow(0, 0, 0,             0, 0,            0, 0, 0, 16'h0000, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst_first) doReset();
         applyStimulus(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
         @(negedge clk);
         checkOutput($sformatf("table_row%0d", i), tbl[i].exp);
         @(posedge clk);
         #1;
      end

      // Reset asserted in LO must drop tube_we without a clock edge.
      doReset();
      applyStimulus(1'b1, 32'h1111_2222, 1'b0, '0);
      modelCycle("rstlo_xfer");
      applyStimulus(1'b0, '0, 1'b0, '0);
      modelCycle("rstlo_hi");
      @(negedge clk);
      modelEval();
      checkOutput("rstlo_lo_beat", {e_r0, e_r1, e_we, e_num, e_tick, e_busy});
      rst = 1'b1;
      #1;
      n_checks++;
      if (tube_we !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL async_reset_drop: got tube_we=%b busy=%b, expected 0/0", tube_we, busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
      applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, '0);
      modelCycle("cafe_xfer");
      applyStimulus(1'b0, '0, 1'b0, '0);
      for (int k = 0; k < 3; k++) modelCycle("cafe_beats");

      // Repeated word: rewritten only when duplicate suppression is absent.
      doReset();
      writeWord("dedup_first", 32'h0000_0042, b1);
      writeWord("dedup_repeat", 32'h0000_0042, b2);
      writeWord("dedup_new", 32'h0000_0043, b3);
      n_checks++;
      if (b1 != 2 || b2 != (DEDUP ? 0 : 2) || b3 != 2) begin
         n_fail++;
         $display("[TB] FAIL dedup_beats: got %0d/%0d/%0d beats, expected 2/%0d/2",
                  b1, b2, b3, DEDUP ? 0 : 2);
      end

      // Randomized traffic that obeys the hold-until-ready rule.
      doReset();
      v0 = 1'b0;
      v1 = 1'b0;
      d0 = '0;
      d1 = '0;
      for (int c = 0; c < 400; c++) begin
         if (!v0) begin
            if ($urandom_range(0, 2) == 0) begin
               v0 = 1'b1;
               d0 = pickWord();
            end
         end else if ($urandom_range(0, 15) == 0) begin
            v0 = 1'b0;
         end
         if (!v1) begin
            if ($urandom_range(0, 2) == 0) begin
               v1 = 1'b1;
               d1 = pickWord();
            end
         end else if ($urandom_range(0, 15) == 0) begin
            v1 = 1'b0;
         end
         applyStimulus(v0, d0, v1, d1);
         modelCycle("random");
         if (e_r0) v0 = 1'b0;
         if (e_r1) v1 = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
